heartbeat_tx: RTL

Upstream transmitter for wall-clock heartbeats; the upstream counterpart of the downstream time tracking in the time manager.
- Counts `unit_pulse` ticks.
- Every `hb_period` time units, snapshots `time_elapsed` and emits it as one or two tagged words on a valid/ack channel toward the PC.
- The PC uses the heartbeats to learn FPGA wall time and pace its `PC_time_elapsed` stream.

---
 rtl/heartbeat_pkg.sv | 23 ++
 rtl/heartbeat_tx_if.sv | 20 ++
 rtl/hb_period_counter.sv | 41 ++++
 rtl/heartbeat_tx.sv | 137 +++++++++++++
 4 files changed

// File: rtl/heartbeat_pkg.sv
// heartbeat_pkg
// Shared types and default widths for the heartbeat transmitter slice.
//   hb_tag_t    : tag bit placed in the MSB of every heartbeat word
//   hb_state_t  : transmitter message state
//   HB_NTIME_HI : default width of the high half of wall time
//   HB_NTIME_LO : default width of the low half of wall time
package heartbeat_pkg;

  localparam int HB_NTIME_HI = 20;
  localparam int HB_NTIME_LO = 20;

  typedef enum logic {
    HB_LO = 1'b0,
    HB_HI = 1'b1
  } hb_tag_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND_HI,
    SEND_LO
  } hb_state_t;

endpackage

// File: rtl/heartbeat_tx_if.sv
// heartbeat_tx_if
// Valid/ack channel carrying tagged heartbeat words toward the PC.
//   hb_out_v : word valid (transmitter drives)
//   hb_out_d : {tag, payload}, Ntime_lo+1 bits (transmitter drives)
//   hb_out_a : word accepted (receiver drives)
// Modports: master = transmitter side, slave = receiver side.
interface heartbeat_tx_if
  import heartbeat_pkg::*;
#(
  parameter int Ntime_lo = HB_NTIME_LO
) ();

  logic                hb_out_v;
  logic [Ntime_lo:0]   hb_out_d;
  logic                hb_out_a;

  modport master (output hb_out_v, output hb_out_d, input hb_out_a);
  modport slave  (input hb_out_v, input hb_out_d, output hb_out_a);

endinterface

// File: rtl/hb_period_counter.sv
// hb_period_counter
// Counts unit_pulse ticks and raises a one-cycle trigger every hb_period units.
//   clk, reset  : system clock, synchronous active-high reset
//   unit_pulse  : one pulse per time unit
//   hb_period   : units between triggers, 0 disables and holds the count at 0
//   trigger     : combinational, high with the unit_pulse that closes a period
module hb_period_counter
  import heartbeat_pkg::*;
#(
  parameter int Nperiod = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               unit_pulse,
  input  logic [Nperiod-1:0] hb_period,
  output logic               trigger
);

  localparam logic [Nperiod-1:0] ONE = {{(Nperiod-1){1'b0}}, 1'b1};

  logic [Nperiod-1:0] cnt;
  logic               at_end;

  // A period shortened below the current count is not special-cased: the
  // count simply runs on and wraps at Nperiod bits before matching again.
  always_comb begin
    at_end  = (cnt == (hb_period - ONE));
    trigger = unit_pulse && (hb_period != '0) && at_end;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (hb_period == '0) begin
      cnt <= '0;
    end else if (unit_pulse) begin
      cnt <= at_end ? '0 : (cnt + ONE);
    end
  end

endmodule

// File: rtl/heartbeat_tx.sv
// heartbeat_tx
// Periodically snapshots wall time and sends it to the PC as tagged words:
// an optional HI word (when the high half changed or a resend was forced)
// followed by a LO word.
//   clk, reset    : system clock, synchronous active-high reset
//   unit_pulse    : one pulse per time unit from the time manager
//   time_elapsed  : current wall time {hi, lo}
//   hb_period     : time units between heartbeats, 0 disables
//   force_hi      : pulse, next heartbeat must carry the HI word
//   hb            : heartbeat_tx_if.master (hb_out_v / hb_out_d / hb_out_a)
//   hb_dropped    : coalesced-trigger count, only with HEARTBEAT_TX_DROP_CNT_EN
// Build option: define HEARTBEAT_TX_DROP_CNT_EN to add the hb_dropped counter.
module heartbeat_tx
  import heartbeat_pkg::*;
#(
  parameter int Ntime_hi = HB_NTIME_HI,
  parameter int Ntime_lo = HB_NTIME_LO,
  parameter int Nperiod  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         unit_pulse,
  input  logic [Ntime_hi+Ntime_lo-1:0] time_elapsed,
  input  logic [Nperiod-1:0]           hb_period,
  input  logic                         force_hi,
  heartbeat_tx_if.master               hb
`ifdef HEARTBEAT_TX_DROP_CNT_EN
  ,
  output logic [15:0]                  hb_dropped
`endif
);

  hb_state_t            state;
  logic                 trigger;
  logic                 pending;
  logic                 force_flag;
  logic [Ntime_hi-1:0]  last_hi;
  logic [Ntime_hi-1:0]  snap_hi;
  logic [Ntime_lo-1:0]  snap_lo;
  logic                 out_v;
  logic [Ntime_lo:0]    out_d;

  logic [Ntime_hi-1:0]  cur_hi;
  logic [Ntime_lo-1:0]  cur_lo;
  logic [Ntime_lo-1:0]  cur_hi_ext;

  hb_period_counter #(
    .Nperiod (Nperiod)
  ) u_period (
    .clk        (clk),
    .reset      (reset),
    .unit_pulse (unit_pulse),
    .hb_period  (hb_period),
    .trigger    (trigger)
  );

  // Split the live time and zero-extend the high half into a LO-sized payload.
  always_comb begin
    cur_hi     = time_elapsed[Ntime_hi+Ntime_lo-1:Ntime_lo];
    cur_lo     = time_elapsed[Ntime_lo-1:0];
    cur_hi_ext = '0;
    cur_hi_ext[Ntime_hi-1:0] = cur_hi;
  end

  // Message sequencer. The snapshot is taken when a heartbeat starts, so
  // triggers coalesced while busy still report the newest time. Set requests
  // (trigger, force_hi) are written last so they win over same-edge clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      out_v      <= 1'b0;
      out_d      <= '0;
      pending    <= 1'b0;
      force_flag <= 1'b1;
      last_hi    <= '0;
      snap_hi    <= '0;
      snap_lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pending) begin
            snap_hi <= cur_hi;
            snap_lo <= cur_lo;
            out_v   <= 1'b1;
            pending <= 1'b0;
            if (force_flag || (cur_hi != last_hi)) begin
              state <= SEND_HI;
              out_d <= {HB_HI, cur_hi_ext};
            end else begin
              state <= SEND_LO;
              out_d <= {HB_LO, cur_lo};
            end
          end
        end
        SEND_HI: begin
          if (hb.hb_out_a) begin
            last_hi    <= snap_hi;
            force_flag <= 1'b0;
            out_d      <= {HB_LO, snap_lo};
            state      <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (hb.hb_out_a) begin
            out_v <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          out_v <= 1'b0;
          state <= IDLE;
        end
      endcase
      if (trigger) begin
        pending <= 1'b1;
      end
      if (force_hi) begin
        force_flag <= 1'b1;
      end
    end
  end

  assign hb.hb_out_v = out_v;
  assign hb.hb_out_d = out_d;

`ifdef HEARTBEAT_TX_DROP_CNT_EN
  // Counts triggers that found a heartbeat already pending, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      hb_dropped <= 16'h0000;
    end else if (trigger && pending && (hb_dropped != 16'hFFFF)) begin
      hb_dropped <= hb_dropped + 16'h0001;
    end
  end
`endif

endmodule
